convolution_core: RTL and testbench

Fixed-point 2-D convolution engine for the accelerator datapath. It reads input-feature-map pixels and filter weights from a single read-only input memory. It computes a stride-2, unpadded FILTER_WIDTH×FILTER_WIDTH convolution per filter and per channel, and accumulates channels through read-modify-write of an output-feature-map memory. Both memories are external and use a fixed-latency chip-enable/data-valid handshake.

---
 rtl/conv_pkg.sv | 70 +++++++
 rtl/conv_window_mac.sv | 72 +++++++
 rtl/convolution_core.sv | 234 +++++++++++++++++++++++
 tb/tb_convolution_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_pkg                                                        |
// | Purpose  : Shared definitions for the convolution engine: default          |
// |            geometry, derived-width helpers, memory-layout helpers and the  |
// |            control FSM state encoding.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package conv_pkg;

   // Default geometry of the engine.
   localparam int N_FILTER_DEF       = 16;
   localparam int N_CHANNEL_DEF      = 3;
   localparam int X_SIZE_DEF         = 32;
   localparam int FILTER_WIDTH_DEF   = 3;
   localparam int CONVS_PER_LINE_DEF = 15;
   localparam int MEM_SIZE_DEF       = 12;
   localparam int INPUT_SIZE_DEF     = 8;
   localparam int CARRY_SIZE_DEF     = 4;
   localparam int SHIFT_DEF          = 8;

   // Output word width W.
   function automatic int out_width(input int input_size, input int carry_size);
      return 2 * input_size + carry_size;
   endfunction

   // Full-precision signed product of two input words.
   function automatic int prod_width(input int input_size);
      return 2 * (2 * input_size);
   endfunction

   // Window sum: four guard bits cover up to 16 taps without overflow.
   function automatic int sum_width(input int input_size);
      return prod_width(input_size) + 4;
   endfunction

   // First weight address: weights sit directly after all channel planes.
   function automatic int wbase(input int n_channel, input int x_size);
      return n_channel * x_size * x_size;
   endfunction

   // Number of output words per filter plane.
   function automatic int plane_size(input int convs_per_line);
      return convs_per_line * convs_per_line;
   endfunction

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int W_DEF      = INPUT_SIZE_DEF * 2 + CARRY_SIZE_DEF;
   localparam int PROD_W_DEF = 2 * (2 * INPUT_SIZE_DEF);
   localparam int SUM_W_DEF  = PROD_W_DEF + 4;
   localparam int WBASE_DEF  = N_CHANNEL_DEF * X_SIZE_DEF * X_SIZE_DEF;
   localparam int PLANE_DEF  = CONVS_PER_LINE_DEF * CONVS_PER_LINE_DEF;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_W    = 3'd1,
      FETCH_PIX = 3'd2,
      MAC       = 3'd3,
      RD_OFMAP  = 3'd4,
      WR_OFMAP  = 3'd5,
      ADVANCE   = 3'd6,
      DONE      = 3'd7
   } conv_state_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_window_mac                                                 |
// | Purpose  : Holds one FW x FW weight window and one FW x FW pixel window    |
// |            and forms P = (sum of signed pixel*weight) >>> SHIFT,           |
// |            truncated to the output word width.                             |
// | Ports    : clock, reset (sync, active-low)                                 |
// |            weight_we / pixel_we : store value into tap idx                 |
// |            idx                  : tap index i*FW+j                         |
// |            value                : signed input word                        |
// |            result               : P, combinational from the registers      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module conv_window_mac
   import conv_pkg::*;
#(
   parameter int FILTER_WIDTH = FILTER_WIDTH_DEF,
   parameter int INPUT_SIZE   = INPUT_SIZE_DEF,
   parameter int CARRY_SIZE   = CARRY_SIZE_DEF,
   parameter int SHIFT        = SHIFT_DEF
) (
   input  logic                                            clock,
   input  logic                                            reset,
   input  logic                                            weight_we,
   input  logic                                            pixel_we,
   input  logic [cnt_width(FILTER_WIDTH*FILTER_WIDTH)-1:0] idx,
   input  logic [2*INPUT_SIZE-1:0]                         value,
   output logic [2*INPUT_SIZE+CARRY_SIZE-1:0]              result
);

   localparam int FW2 = FILTER_WIDTH * FILTER_WIDTH;
   localparam int IW  = 2 * INPUT_SIZE;
   localparam int OW  = out_width(INPUT_SIZE, CARRY_SIZE);
   localparam int PW  = prod_width(INPUT_SIZE);
   localparam int SW  = sum_width(INPUT_SIZE);

   logic signed [IW-1:0] weight_q [FW2];
   logic signed [IW-1:0] pixel_q  [FW2];
   logic signed [PW-1:0] prod     [FW2];
   logic signed [SW-1:0] sum;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int t = 0; t < FW2; t++) begin
            weight_q[t] <= '0;
            pixel_q[t]  <= '0;
         end
      end else begin
         if (weight_we) weight_q[idx] <= value;
         if (pixel_we)  pixel_q[idx]  <= value;
      end
   end

   // Both operands are widened as signed values so the product keeps its
   // full precision and sign.
   for (genvar t = 0; t < FW2; t++) begin : g_tap
      assign prod[t] = PW'(weight_q[t]) * PW'(pixel_q[t]);
   end

   always_comb begin
      sum = '0;
      for (int t = 0; t < FW2; t++) begin
         sum = sum + SW'(prod[t]);
      end
   end

   // Arithmetic shift keeps negative sums rounding toward minus infinity;
   // the high bits are simply dropped.
   assign result = OW'(sum >>> SHIFT);

endmodule : conv_window_mac
`default_nettype wire

// File: rtl/convolution_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : convolution_core                                                |
// | Purpose  : Stride-2, unpadded FW x FW fixed-point convolution engine.      |
// |            Loops filter / channel / output row / output column, loads the  |
// |            weights once per (filter, channel), fetches each pixel window   |
// |            from the input memory and accumulates channels into the output  |
// |            memory by read-modify-write.                                    |
// | Ports    : clock, reset (sync, active-low)                                 |
// |            start_conv / end_conv : run control and completion flag         |
// |            debug                 : simulation trace hook, no effect        |
// |            inmem_*               : input memory read port (ce/valid)       |
// |            ofmap_*, pixel_out/in : output memory port (ce/we/valid)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module convolution_core
   import conv_pkg::*;
#(
   parameter int N_FILTER       = N_FILTER_DEF,
   parameter int N_CHANNEL      = N_CHANNEL_DEF,
   parameter int X_SIZE         = X_SIZE_DEF,
   parameter int FILTER_WIDTH   = FILTER_WIDTH_DEF,
   parameter int CONVS_PER_LINE = CONVS_PER_LINE_DEF,
   parameter int MEM_SIZE       = MEM_SIZE_DEF,
   parameter int INPUT_SIZE     = INPUT_SIZE_DEF,
   parameter int CARRY_SIZE     = CARRY_SIZE_DEF,
   parameter int SHIFT          = SHIFT_DEF
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start_conv,
   output logic                               end_conv,
   input  logic                               debug,
   output logic                               inmem_ce,
   output logic [MEM_SIZE-1:0]                inmem_address,
   input  logic                               inmem_valid,
   input  logic [2*INPUT_SIZE-1:0]            inmem_value,
   output logic                               ofmap_ce,
   output logic                               ofmap_we,
   output logic [MEM_SIZE-1:0]                ofmap_address,
   output logic [2*INPUT_SIZE+CARRY_SIZE-1:0] pixel_out,
   input  logic                               ofmap_valid,
   input  logic [2*INPUT_SIZE+CARRY_SIZE-1:0] pixel_in
);

   localparam int OW    = out_width(INPUT_SIZE, CARRY_SIZE);
   localparam int FW2   = FILTER_WIDTH * FILTER_WIDTH;
   localparam int IDX_W = cnt_width(FW2);
   localparam int FB    = cnt_width(N_FILTER);
   localparam int CB    = cnt_width(N_CHANNEL);
   localparam int KB    = cnt_width(CONVS_PER_LINE);
   localparam int IB    = cnt_width(FILTER_WIDTH);
   localparam int WB    = wbase(N_CHANNEL, X_SIZE);
   localparam int PLANE = plane_size(CONVS_PER_LINE);

   localparam logic [FB-1:0] F_LAST = FB'(N_FILTER - 1);
   localparam logic [CB-1:0] C_LAST = CB'(N_CHANNEL - 1);
   localparam logic [KB-1:0] K_LAST = KB'(CONVS_PER_LINE - 1);
   localparam logic [IB-1:0] I_LAST = IB'(FILTER_WIDTH - 1);

   conv_state_t state, state_nxt;

   logic [FB-1:0] f;
   logic [CB-1:0] c;
   logic [KB-1:0] r, k;
   logic [IB-1:0] wi, wj;         // tap row / column inside the window
   logic          pend_in;        // input-memory read outstanding
   logic          pend_of;        // output-memory read outstanding
   logic [OW-1:0] mac_q;          // P of the current window
   logic [OW-1:0] rd_q;           // partial sum read back from the ofmap
   logic [OW-1:0] mac_result;

   logic          in_accept;
   logic          win_last, pos_last, fc_last;
   logic [IDX_W-1:0] win_idx;
   int            pix_lin, w_lin, o_lin;

   // The trace hook is for simulation only and deliberately drives nothing.
   logic unused_debug;
   assign unused_debug = debug;

   // Returned data is only taken while a request is outstanding, so stray
   // valid pulses outside the fetch states are ignored.
   assign in_accept = pend_in && inmem_valid &&
                      ((state == LOAD_W) || (state == FETCH_PIX));
   assign win_last  = (wi == I_LAST) && (wj == I_LAST);
   assign pos_last  = (r == K_LAST) && (k == K_LAST);
   assign fc_last   = (f == F_LAST) && (c == C_LAST);
   assign win_idx   = IDX_W'(int'(wi) * FILTER_WIDTH + int'(wj));

   always_comb begin
      pix_lin = int'(c) * X_SIZE * X_SIZE
              + (2 * int'(r) + int'(wi)) * X_SIZE
              + 2 * int'(k) + int'(wj);
      w_lin   = WB + (int'(f) * N_CHANNEL + int'(c)) * FW2
              + int'(wi) * FILTER_WIDTH + int'(wj);
      o_lin   = int'(f) * PLANE + int'(r) * CONVS_PER_LINE + int'(k);
   end

   conv_window_mac #(
      .FILTER_WIDTH (FILTER_WIDTH),
      .INPUT_SIZE   (INPUT_SIZE),
      .CARRY_SIZE   (CARRY_SIZE),
      .SHIFT        (SHIFT)
   ) u_mac (
      .clock     (clock),
      .reset     (reset),
      .weight_we (in_accept && (state == LOAD_W)),
      .pixel_we  (in_accept && (state == FETCH_PIX)),
      .idx       (win_idx),
      .value     (inmem_value),
      .result    (mac_result)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_conv) state_nxt = LOAD_W;
         LOAD_W:    if (in_accept && win_last) state_nxt = FETCH_PIX;
         FETCH_PIX: if (in_accept && win_last) state_nxt = MAC;
         MAC:       state_nxt = (c != '0) ? RD_OFMAP : WR_OFMAP;
         RD_OFMAP:  if (pend_of && ofmap_valid) state_nxt = WR_OFMAP;
         WR_OFMAP:  state_nxt = ADVANCE;
         ADVANCE: begin
            if (!pos_last)     state_nxt = FETCH_PIX;
            else if (!fc_last) state_nxt = LOAD_W;
            else               state_nxt = DONE;
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         f             <= '0;
         c             <= '0;
         r             <= '0;
         k             <= '0;
         wi            <= '0;
         wj            <= '0;
         pend_in       <= 1'b0;
         pend_of       <= 1'b0;
         mac_q         <= '0;
         rd_q          <= '0;
         end_conv      <= 1'b0;
         inmem_ce      <= 1'b0;
         inmem_address <= '0;
         ofmap_ce      <= 1'b0;
         ofmap_we      <= 1'b0;
         ofmap_address <= '0;
         pixel_out     <= '0;
      end else begin
         // Strobes are single-cycle by construction.
         inmem_ce <= 1'b0;
         ofmap_ce <= 1'b0;
         ofmap_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start_conv) begin
                  end_conv <= 1'b0;
                  f        <= '0;
                  c        <= '0;
                  r        <= '0;
                  k        <= '0;
                  wi       <= '0;
                  wj       <= '0;
               end
            end
            LOAD_W, FETCH_PIX: begin
               if (!pend_in) begin
                  inmem_ce      <= 1'b1;
                  inmem_address <= (state == LOAD_W) ? MEM_SIZE'(w_lin)
                                                     : MEM_SIZE'(pix_lin);
                  pend_in       <= 1'b1;
               end else if (inmem_valid) begin
                  pend_in <= 1'b0;
                  if (wj == I_LAST) begin
                     wj <= '0;
                     wi <= (wi == I_LAST) ? '0 : wi + 1'b1;
                  end else begin
                     wj <= wj + 1'b1;
                  end
               end
            end
            MAC: mac_q <= mac_result;
            RD_OFMAP: begin
               if (!pend_of) begin
                  ofmap_ce      <= 1'b1;
                  ofmap_address <= MEM_SIZE'(o_lin);
                  pend_of       <= 1'b1;
               end else if (ofmap_valid) begin
                  rd_q    <= pixel_in;
                  pend_of <= 1'b0;
               end
            end
            WR_OFMAP: begin
               ofmap_ce      <= 1'b1;
               ofmap_we      <= 1'b1;
               ofmap_address <= MEM_SIZE'(o_lin);
               // Channel 0 starts the plane; later channels add modulo 2^W.
               pixel_out     <= (c == '0) ? mac_q : rd_q + mac_q;
            end
            ADVANCE: begin
               if (k != K_LAST) begin
                  k <= k + 1'b1;
               end else begin
                  k <= '0;
                  if (r != K_LAST) begin
                     r <= r + 1'b1;
                  end else begin
                     r <= '0;
                     if (c != C_LAST) begin
                        c <= c + 1'b1;
                     end else begin
                        c <= '0;
                        f <= (f == F_LAST) ? '0 : f + 1'b1;
                     end
                  end
               end
            end
            DONE: end_conv <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule : convolution_core
`default_nettype wire

// File: tb/tb_convolution_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_convolution_core                                             |
// | Purpose  : Directed bench for convolution_core on a reduced geometry       |
// |            (2 filters, 3 channels, 7x7 input, 3x3 output) with behavioural |
// |            input ROM / output RAM of selectable read latency.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_convolution_core;

   localparam int NF  = 2;
   localparam int NC  = 3;
   localparam int XS  = 7;
   localparam int FW  = 3;
   localparam int CPL = 3;
   localparam int MS  = 8;
   localparam int IS  = 8;
   localparam int CS  = 4;
   localparam int SH  = 8;
   localparam int W   = 2 * IS + CS;
   localparam int WBASE  = NC * XS * XS;
   localparam int MDEPTH = 1 << MS;
   localparam int EXP_WR = NF * NC * CPL * CPL;
   localparam int EXP_RD = NF * (NC - 1) * CPL * CPL;
   localparam int EXP_IN = NF * NC * (FW * FW + CPL * CPL * FW * FW);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start_conv = 1'b0;
   logic          debug = 1'b0;
   logic          end_conv;
   logic          inmem_ce;
   logic [MS-1:0] inmem_address;
   logic          inmem_valid;
   logic [2*IS-1:0] inmem_value;
   logic          ofmap_ce;
   logic          ofmap_we;
   logic [MS-1:0] ofmap_address;
   logic [W-1:0]  pixel_out;
   logic          ofmap_valid;
   logic [W-1:0]  pixel_in;

   int lat = 2;
   logic [15:0]  inrom [MDEPTH];
   logic [W-1:0] ofram [MDEPTH];
   logic [7:0]   in_vp = '0;
   logic [7:0]   of_vp = '0;
   logic [15:0]  in_dp [8];
   logic [W-1:0] of_dp [8];
   int n_in = 0, n_rd = 0, n_wr = 0, n_end = 0;
   logic end_q = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   convolution_core #(
      .N_FILTER (NF), .N_CHANNEL (NC), .X_SIZE (XS), .FILTER_WIDTH (FW),
      .CONVS_PER_LINE (CPL), .MEM_SIZE (MS), .INPUT_SIZE (IS),
      .CARRY_SIZE (CS), .SHIFT (SH)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start_conv    (start_conv),
      .end_conv      (end_conv),
      .debug         (debug),
      .inmem_ce      (inmem_ce),
      .inmem_address (inmem_address),
      .inmem_valid   (inmem_valid),
      .inmem_value   (inmem_value),
      .ofmap_ce      (ofmap_ce),
      .ofmap_we      (ofmap_we),
      .ofmap_address (ofmap_address),
      .pixel_out     (pixel_out),
      .ofmap_valid   (ofmap_valid),
      .pixel_in      (pixel_in)
   );

   always #5 clock = ~clock;

   // Memory models: a request sampled at an edge returns `lat` cycles later.
   always @(posedge clock) begin
      in_vp <= {in_vp[6:0], inmem_ce};
      of_vp <= {of_vp[6:0], ofmap_ce & ~ofmap_we};
      for (int i = 7; i > 0; i--) begin
         in_dp[i] <= in_dp[i-1];
         of_dp[i] <= of_dp[i-1];
      end
      in_dp[0] <= inrom[inmem_address];
      of_dp[0] <= ofram[ofmap_address];
      if (inmem_ce) n_in <= n_in + 1;
      if (ofmap_ce && !ofmap_we) n_rd <= n_rd + 1;
      if (ofmap_ce && ofmap_we) begin
         ofram[ofmap_address] <= pixel_out;
         n_wr <= n_wr + 1;
      end
      end_q <= end_conv;
      if (end_conv && !end_q) n_end <= n_end + 1;
   end

   assign inmem_valid = in_vp[lat-1];
   assign inmem_value = in_dp[lat-1];
   assign ofmap_valid = of_vp[lat-1];
   assign pixel_in    = of_dp[lat-1];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // mode 0: pixels 0x0010 / weights 0x0010
   // mode 1: pixels 0x0010 / weights 0xFFF0
   // mode 2: ramp pixels, centre-only weight 0x0100 (f0) or 0x0200 (f1)
   // mode 3: pixels and weights 0x7FFF (wide sum, output wrap)
   task automatic load_mem(input int mode);
      for (int a = 0; a < MDEPTH; a++) inrom[a] = 16'h0000;
      for (int c = 0; c < NC; c++)
         for (int y = 0; y < XS; y++)
            for (int x = 0; x < XS; x++)
               case (mode)
                  2:       inrom[c*XS*XS + y*XS + x] = 16'(c*64 + y*8 + x);
                  3:       inrom[c*XS*XS + y*XS + x] = 16'h7FFF;
                  default: inrom[c*XS*XS + y*XS + x] = 16'h0010;
               endcase
      for (int f = 0; f < NF; f++)
         for (int c = 0; c < NC; c++)
            for (int i = 0; i < FW; i++)
               for (int j = 0; j < FW; j++)
                  case (mode)
                     0: inrom[WBASE + ((f*NC + c)*FW + i)*FW + j] = 16'h0010;
                     1: inrom[WBASE + ((f*NC + c)*FW + i)*FW + j] = 16'hFFF0;
                     2: inrom[WBASE + ((f*NC + c)*FW + i)*FW + j] =
                           (i == 1 && j == 1) ? ((f == 0) ? 16'h0100 : 16'h0200) : 16'h0000;
                     default: inrom[WBASE + ((f*NC + c)*FW + i)*FW + j] = 16'h7FFF;
                  endcase
   endtask

   // Hand-derived results:
   //  mode 0: 9 taps * 256 >>> 8 = 9 per channel, 3 channels -> 27
   //  mode 1: -27 in 20 bits -> 0xFFFE5
   //  mode 2: (f+1) * sum_c (64c + 8(2r+1) + 2k+1) = (f+1)*(219 + 48r + 6k)
   //  mode 3: 9*0x3FFF0001 >>> 8 = 0x23FF700 -> 0xFF700 per channel;
   //          three channels modulo 2^20 -> 0xFE500
   function automatic logic [W-1:0] exp_val(input int mode, input int f, input int r, input int k);
      case (mode)
         0:       return 20'h0001B;
         1:       return 20'hFFFE5;
         2:       return W'((f + 1) * (219 + 48*r + 6*k));
         default: return 20'hFE500;
      endcase
   endfunction

   task automatic run_conv(input string tag, input int mode, input bit pulse_busy);
      int w0, r0, i0, e0;
      bit done;
      w0 = n_wr; r0 = n_rd; i0 = n_in; e0 = n_end;
      done = 1'b0;
      @(negedge clock); start_conv = 1'b1;
      @(negedge clock); start_conv = 1'b0;
      check_eq({tag, "_end_clr"}, end_conv, 0);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clock);
         if (pulse_busy && cyc == 300) start_conv = 1'b1;
         if (pulse_busy && cyc == 301) start_conv = 1'b0;
         if (end_conv) begin
            done = 1'b1;
            break;
         end
      end
      check_eq({tag, "_done"}, done, 1);
      repeat (2) @(negedge clock);
      check_eq({tag, "_end_rises"}, n_end - e0, 1);
      check_eq({tag, "_n_write"}, n_wr - w0, EXP_WR);
      check_eq({tag, "_n_read"},  n_rd - r0, EXP_RD);
      check_eq({tag, "_n_inmem"}, n_in - i0, EXP_IN);
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < CPL; r++)
            for (int k = 0; k < CPL; k++)
               check_eq($sformatf("%s_of_f%0d_r%0d_k%0d", tag, f, r, k),
                        ofram[f*CPL*CPL + r*CPL + k], exp_val(mode, f, r, k));
   endtask

   initial begin
      int snap;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("reset_outputs",
               {end_conv, inmem_ce, inmem_address, ofmap_ce, ofmap_we, ofmap_address, pixel_out}, 0);
      reset = 1'b1;
      @(negedge clock);

      load_mem(0); run_conv("ones", 0, 0);
      load_mem(1); run_conv("neg",  1, 0);
      load_mem(2); run_conv("ramp", 2, 0);
      load_mem(3); run_conv("wrap", 3, 0);

      // Reset in the middle of a run, then a clean run.
      load_mem(0);
      @(negedge clock); start_conv = 1'b1;
      @(negedge clock); start_conv = 1'b0;
      repeat (1000) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst_mid_outputs",
               {end_conv, inmem_ce, inmem_address, ofmap_ce, ofmap_we, ofmap_address, pixel_out}, 0);
      reset = 1'b1;
      snap = n_in;
      repeat (10) @(negedge clock);
      check_eq("rst_idle_quiet", n_in - snap, 0);
      run_conv("rst_rerun", 0, 0);

      load_mem(1); run_conv("busy_start", 1, 1);

      lat = 1; debug = 1'b1;
      load_mem(2); run_conv("lat1", 2, 0);
      lat = 4; debug = 1'b0;
      load_mem(3); run_conv("lat4", 3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_convolution_core
`default_nettype wire
